// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: credit-gated imem requests, in-order response FIFO, redirect flush.
// Optional misaligned-redirect trap enabled with `define FETCH_MISALIGN_TRAP_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    input  logic        ifid_ready,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        fetch_trap
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   deliver_pc_q, deliver_pc_d;
    logic          trap_q, trap_d;

    logic          gnt, rsp, push, pop;
    logic [31:0]   tgt;
    logic [CW:0]   credits;

    assign tgt     = redirect_pc & ~32'h3;
    assign credits = {1'b0, cnt_q} + {1'b0, out_q};

    // Slots are reserved at grant, so outstanding responses count against the FIFO.
    assign imem_req = !rst && !redirect && !trap_q && (credits < LIMIT);
    assign gnt      = imem_req && imem_gnt;
    assign rsp      = imem_rvalid && (out_q != '0);
    assign push     = rsp && (drop_q == '0) && !redirect;
    assign pop      = !redirect && (cnt_q != '0) && ifid_ready;

    assign imem_addr  = fetch_pc_q;
    assign ifid_valid = cnt_q != '0;
    assign ifid_instr = mem_q[rptr_q];
    assign ifid_pc    = deliver_pc_q;
    assign fetch_trap = trap_q;

    always_comb begin
        out_d        = out_q + CW'(gnt) - CW'(rsp);
        drop_d       = drop_q - CW'(rsp && (drop_q != '0));
        cnt_d        = cnt_q + CW'(push) - CW'(pop);
        fetch_pc_d   = gnt ? fetch_pc_q + 32'd4 : fetch_pc_q;
        deliver_pc_d = pop ? deliver_pc_q + 32'd4 : deliver_pc_q;
        trap_d       = trap_q;
        if (redirect) begin
            drop_d       = out_q - CW'(rsp);
            cnt_d        = '0;
            fetch_pc_d   = tgt;
            deliver_pc_d = tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_d       = redirect_pc[1:0] != 2'b00;
`else
            trap_d       = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q       <= '0;
            wptr_q       <= '0;
            cnt_q        <= '0;
            out_q        <= '0;
            drop_q       <= '0;
            fetch_pc_q   <= RESET_PC;
            deliver_pc_q <= RESET_PC;
            trap_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            fetch_pc_q   <= fetch_pc_d;
            deliver_pc_q <= deliver_pc_d;
            trap_q       <= trap_d;
            if (redirect) begin
                rptr_q <= '0;
                wptr_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wptr_q] <= imem_rdata;
                    wptr_q        <= wptr_q + 1'b1;
                end
                if (pop) rptr_q <= rptr_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic against a queue-based model.
// Trap scenarios follow `define FETCH_MISALIGN_TRAP_EN when set.
module tb_fetch_sequencer;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ifid_valid;
    logic        ifid_ready = 1'b0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        fetch_trap;

    fetch_sequencer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_ready(ifid_ready),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .fetch_trap(fetch_trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    pend_t       pq[$];
    int          buf_cnt;
    logic [31:0] req_pc;
    logic [31:0] exp_pc;
    bit          trap_m;
    logic [31:0] key;
    int          cyc;
    int          lat_lo, lat_hi;
    int          nvec, nerr;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; ifid_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_pc", ifid_pc, RESET_PC);
        chk("rst_instr", ifid_instr, 0);
        chk("rst_trap", fetch_trap, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pq.delete();
        buf_cnt = 0;
        req_pc  = RESET_PC;
        exp_pc  = RESET_PC;
        trap_m  = 1'b0;
    endtask

    task automatic step(input bit rd, input logic [31:0] tgt, input bit g, input bit rdy);
        bit    rv, exp_req, popd;
        pend_t h;
        rv = (pq.size() != 0) && (pq[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mdata(pq[0].addr) : $urandom;
        redirect    = rd;
        redirect_pc = tgt;
        imem_gnt    = g;
        ifid_ready  = rdy;
        @(negedge clk);
        exp_req = !rd && !trap_m && (pq.size() + buf_cnt < DEPTH);
        chk("req", imem_req, exp_req);
        if (exp_req) chk("addr", imem_addr, req_pc);
        chk("valid", ifid_valid, buf_cnt != 0);
        if (buf_cnt != 0) begin
            chk("pc", ifid_pc, exp_pc);
            chk("instr", ifid_instr, mdata(exp_pc));
        end
        chk("trap", fetch_trap, trap_m);
        popd = !rd && (buf_cnt != 0) && rdy;
        if (rd) begin
            if (rv) void'(pq.pop_front());
            foreach (pq[i]) pq[i].stale = 1'b1;
            buf_cnt = 0;
            req_pc  = tgt & ~32'h3;
            exp_pc  = req_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_m  = tgt[1:0] != 2'b00;
`endif
        end else begin
            if (rv) begin
                h = pq.pop_front();
                if (!h.stale) buf_cnt++;
            end
            if (exp_req && g) begin
                h.addr  = req_pc;
                h.due   = cyc + $urandom_range(lat_lo, lat_hi);
                h.stale = 1'b0;
                pq.push_back(h);
                req_pc += 32'd4;
            end
            if (popd) begin
                buf_cnt--;
                exp_pc += 32'd4;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        nvec = 0; nerr = 0; cyc = 0;
        key = 32'h0; lat_lo = 1; lat_hi = 1;

        // Streaming with 1-cycle memory, data equals address.
        do_reset();
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1);

        // Decode stall: FIFO fills, credits run out, then drains in order.
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1);

        // Redirect with two requests in flight on a slower memory.
        key = 32'h5A5A_0F0F;
        do_reset();
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        step(1, 32'h100, 1, 1);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 1);

        // Redirect colliding with a response and a pending grant.
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        step(1, 32'h300, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

        // Misaligned redirect, then aligned recovery.
        step(1, 32'h102, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        step(1, 32'h200, 1, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1);

        // Random traffic, with a reset partway through.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 99) < 3, $urandom & 32'h0000_0FFF,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
